// File: rtl/axi_sb_pkg.sv
// Shared record type, field indices and field-compare helper for the transaction scoreboard.
// Record widths are fixed here; every scoreboard instance shares them.
package axi_sb_pkg;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SIG_W  = 32;
    localparam int NFLD   = 5;

    localparam int FLD_CMD  = 4;
    localparam int FLD_ID   = 3;
    localparam int FLD_ADDR = 2;
    localparam int FLD_LEN  = 1;
    localparam int FLD_SIG  = 0;

    // cmd: 0 = write, 1 = read
    typedef struct packed {
        logic              cmd;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIG_W-1:0]  sig;
    } txn_t;

    localparam int TXN_W = $bits(txn_t);

    function automatic logic [NFLD-1:0] txn_diff(input txn_t m, input txn_t s,
                                                 input logic [NFLD-1:0] mask);
        logic [NFLD-1:0] d;
        d           = '0;
        d[FLD_CMD]  = (m.cmd  != s.cmd);
        d[FLD_ID]   = (m.id   != s.id);
        d[FLD_ADDR] = (m.addr != s.addr);
        d[FLD_LEN]  = (m.len  != s.len);
        d[FLD_SIG]  = (m.sig  != s.sig);
        return d & mask;
    endfunction

endpackage

// File: rtl/axi_sb_if.sv
// Record taps feeding the scoreboard: one valid/ready/record triple per side.
// ready only reports FIFO space; a tap that ignores it loses the record.
interface axi_sb_if;
    logic              mst_valid;
    logic              mst_ready;
    axi_sb_pkg::txn_t  mst_rec;
    logic              slv_valid;
    logic              slv_ready;
    axi_sb_pkg::txn_t  slv_rec;

    modport master (output mst_valid, output mst_rec, input mst_ready,
                    output slv_valid, output slv_rec, input slv_ready);
    modport slave  (input mst_valid, input mst_rec, output mst_ready,
                    input slv_valid, input slv_rec, output slv_ready);
endinterface

// File: rtl/axi_sb_fifo.sv
// Show-ahead synchronous FIFO: head valid the cycle after the push, pop consumes it.
// No internal guarding: caller pushes only when !full and pops only when !empty.
module axi_sb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer bit separates full from empty when the indices coincide
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/axi_txn_scoreboard.sv
// In-order pairwise compare of master/slave tap records; result counted 1 cycle after the pop.
// Taps never stall: a record offered while its FIFO is full is dropped and flags overflow.
module axi_txn_scoreboard
    import axi_sb_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   aclk,
    input  logic                   areset,
    axi_sb_if.slave                tap,
    input  logic [NFLD-1:0]        cmp_mask,
    input  logic                   clr,
    output logic [CNT_W-1:0]       cmp_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic                   mismatch,
    output logic [NFLD-1:0]        first_err_fields,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic                   timeout,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] mst_level,
    output logic [$clog2(DEPTH):0] slv_level
);
    txn_t            mst_head, slv_head;
    logic            mst_full, mst_empty, slv_full, slv_empty;
    logic            mst_push, slv_push, pop;
    logic            cmp_vld;
    logic [NFLD-1:0] cmp_diff;
    logic [ADDR_W-1:0] cmp_addr;

    assign tap.mst_ready = !mst_full && !areset;
    assign tap.slv_ready = !slv_full && !areset;
    assign mst_push      = tap.mst_valid && tap.mst_ready;
    assign slv_push      = tap.slv_valid && tap.slv_ready;
    assign pop           = !mst_empty && !slv_empty;

    axi_sb_fifo #(.WIDTH(TXN_W), .DEPTH(DEPTH)) u_mst_fifo (
        .aclk(aclk), .areset(areset), .push(mst_push), .pop(pop), .din(tap.mst_rec),
        .dout(mst_head), .full(mst_full), .empty(mst_empty), .level(mst_level)
    );

    axi_sb_fifo #(.WIDTH(TXN_W), .DEPTH(DEPTH)) u_slv_fifo (
        .aclk(aclk), .areset(areset), .push(slv_push), .pop(pop), .din(tap.slv_rec),
        .dout(slv_head), .full(slv_full), .empty(slv_empty), .level(slv_level)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            cmp_vld          <= 1'b0;
            cmp_diff         <= '0;
            cmp_addr         <= '0;
            cmp_cnt          <= '0;
            err_cnt          <= '0;
            mismatch         <= 1'b0;
            first_err_fields <= '0;
            first_err_addr   <= '0;
            overflow         <= 1'b0;
        end else begin
            cmp_vld  <= pop;
            cmp_diff <= txn_diff(mst_head, slv_head, cmp_mask);
            cmp_addr <= mst_head.addr;
            // clr drops whatever result lands in the same cycle
            if (clr) begin
                cmp_cnt          <= '0;
                err_cnt          <= '0;
                mismatch         <= 1'b0;
                first_err_fields <= '0;
                first_err_addr   <= '0;
                overflow         <= 1'b0;
            end else begin
                if (cmp_vld) begin
                    if (cmp_cnt != '1) cmp_cnt <= cmp_cnt + 1'b1;
                    if (cmp_diff != '0) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        mismatch <= 1'b1;
                        if (!mismatch) begin
                            first_err_fields <= cmp_diff;
                            first_err_addr   <= cmp_addr;
                        end
                    end
                end
                if ((tap.mst_valid && !tap.mst_ready) || (tap.slv_valid && !tap.slv_ready))
                    overflow <= 1'b1;
            end
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            localparam int ST_W = $clog2(TIMEOUT + 1);
            logic [ST_W-1:0] starve;

            // Only reachable with exactly one FIFO non-empty; saturates at the limit
            always_ff @(posedge aclk) begin
                if (areset || clr) begin
                    starve  <= '0;
                    timeout <= 1'b0;
                end else if (pop || (mst_empty && slv_empty)) begin
                    starve <= '0;
                end else if (starve != ST_W'(TIMEOUT)) begin
                    starve <= starve + 1'b1;
                    if (starve == ST_W'(TIMEOUT - 1)) timeout <= 1'b1;
                end
            end
        end
    endgenerate

endmodule
